// File: rtl/dmux16_route_buffer.sv
// Purpose  : route one valid/ready input word into channel a (sel=0) or b (sel=1),
//            each a DEPTH-entry FIFO drained by its own valid/ready consumer, and
//            count words delivered per channel (wrapping, synchronously clearable).
// Latency  : 1 cycle push-to-head when the channel is empty; no combinational fall-through.
// Backpres.: in_ready = !full of the selected channel only; a full channel refuses a push
//            even when it pops the same cycle, and never stalls the other channel.
// Ports    : clk, rst_n (async active-low); in_data/in_sel/in_valid/in_ready;
//            a_data/a_valid/a_ready, b_data/b_valid/b_ready; clr_count, a_count, b_count.
module dmux16_route_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,    // power of two, >= 2
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    input  logic             clr_count,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Index 0 is channel a, index 1 is channel b.
    logic [1:0]            push_vld;
    logic [1:0]            pop_vld;
    logic [1:0]            out_rdy;
    logic [1:0]            full_q;
    logic [1:0]            head_vld;
    logic [1:0][WIDTH-1:0] head_dat;
    logic [1:0][CNT_W-1:0] cnt_dat;

    assign out_rdy  = {b_ready, a_ready};
    // Full is judged from state only, so a same-cycle pop never opens a slot.
    assign in_ready = !full_q[in_sel];
    assign push_vld = {in_valid && in_ready && in_sel, in_valid && in_ready && !in_sel};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        // Pointers carry an extra wrap bit: equal -> empty, only wrap differs -> full.
        logic [AW:0]      wr_ptr;
        logic [AW:0]      rd_ptr;
        logic [WIDTH-1:0] mem [DEPTH];
        logic [CNT_W-1:0] cnt;
        logic             empty;

        assign empty       = (wr_ptr == rd_ptr);
        assign full_q[c]   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign head_vld[c] = !empty;
        // Storage is not reset; gating with empty gives 0 on the output when idle.
        assign head_dat[c] = empty ? '0 : mem[rd_ptr[AW-1:0]];
        assign pop_vld[c]  = !empty && out_rdy[c];
        assign cnt_dat[c]  = cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push_vld[c]) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop_vld[c]) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // Clear wins over a same-cycle delivery.
                if (clr_count) begin
                    cnt <= '0;
                end else if (pop_vld[c]) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push_vld[c]) begin
                mem[wr_ptr[AW-1:0]] <= in_data;
            end
        end
    end

    assign a_valid = head_vld[0];
    assign b_valid = head_vld[1];
    assign a_data  = head_dat[0];
    assign b_data  = head_dat[1];
    assign a_count = cnt_dat[0];
    assign b_count = cnt_dat[1];

endmodule
